decode: RTL and testbench

DECODE -- requirements
Module: decode

---
 rtl/decode.sv | 163 ++++++++++++++++
 tb/tb_decode.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/decode.sv
// decode -- instruction decode stage.
//
// Latches the fetched PC/instruction/valid and splits the latched word into
// opcode, funct, register-index and sign-extended immediate fields. Also holds
// the 32x32 integer register file and reads both source operands, bypassing a
// same-cycle writeback so a consumer never sees a stale value.
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   STALL, FLUSH             hold / invalidate the input latch (FLUSH wins)
//   F_PC, F_INST, F_VALID    fetched instruction
//   W_VALID, W_REG_D,
//   W_REG_D_V                register-file write port
//   D_PC, D_INST, D_VALID    latched instruction
//   D_OPCODE/FUNCT3/FUNCT7   raw fields of D_INST
//   D_IMM                    sign-extended immediate (0 for R/unknown)
//   D_REG_D/S1/S2            rd/rs1/rs2 (0 when the format has no such field)
//   D_REG_S1_V, D_REG_S2_V   source operand values
module decode (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic [31:0] F_PC,
  input  logic [31:0] F_INST,
  input  logic        F_VALID,
  input  logic        W_VALID,
  input  logic [4:0]  W_REG_D,
  input  logic [31:0] W_REG_D_V,
  output logic [31:0] D_PC,
  output logic [31:0] D_INST,
  output logic        D_VALID,
  output logic [6:0]  D_OPCODE,
  output logic [2:0]  D_FUNCT3,
  output logic [6:0]  D_FUNCT7,
  output logic [31:0] D_IMM,
  output logic [4:0]  D_REG_D,
  output logic [4:0]  D_REG_S1,
  output logic [4:0]  D_REG_S2,
  output logic [31:0] D_REG_S1_V,
  output logic [31:0] D_REG_S2_V
);

  localparam logic [31:0] NOP = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [2:0] {
    C_UNK, C_R, C_I, C_S, C_B, C_U, C_J
  } iclass_e;

  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        r_valid;
  // Entry 0 exists only to keep indexing simple; it is reset and never
  // written, and reads of index 0 are forced to zero anyway.
  logic [31:0] r_rf [0:31];

  iclass_e     w_cls;
  logic [31:0] w_imm;
  logic [4:0]  w_rd, w_rs1, w_rs2;

  // ---------------------------------------------------------------- latch
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc    <= '0;
      r_inst  <= NOP;
      r_valid <= 1'b0;
    end else if (FLUSH) begin
      // PC still follows fetch so the bubble carries a meaningful address.
      r_pc    <= F_PC;
      r_inst  <= NOP;
      r_valid <= 1'b0;
    end else if (!STALL) begin
      r_pc    <= F_PC;
      r_inst  <= F_INST;
      r_valid <= F_VALID;
    end
  end

  // -------------------------------------------------------- register file
  // Writes ignore STALL/FLUSH: writeback belongs to an older instruction.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (W_VALID && (W_REG_D != 5'd0)) begin
      r_rf[W_REG_D] <= W_REG_D_V;
    end
  end

  function automatic logic [31:0] rf_read(input logic [4:0] idx);
    if (idx == 5'd0)                     rf_read = '0;
    else if (W_VALID && W_REG_D == idx)  rf_read = W_REG_D_V;
    else                                 rf_read = r_rf[idx];
  endfunction

  // --------------------------------------------------------------- decode
  always_comb begin
    w_cls = C_UNK;
    case (r_inst[6:0])
      7'b0110011:                         w_cls = C_R;
      7'b0010011, 7'b0000011, 7'b1100111: w_cls = C_I;
      7'b0100011:                         w_cls = C_S;
      7'b1100011:                         w_cls = C_B;
      7'b0110111, 7'b0010111:             w_cls = C_U;
      7'b1101111:                         w_cls = C_J;
      default:                            w_cls = C_UNK;
    endcase
  end

  always_comb begin
    w_imm = '0;
    w_rd  = '0;
    w_rs1 = '0;
    w_rs2 = '0;
    case (w_cls)
      C_R: begin
        w_rd  = r_inst[11:7];
        w_rs1 = r_inst[19:15];
        w_rs2 = r_inst[24:20];
      end
      C_I: begin
        w_imm = {{20{r_inst[31]}}, r_inst[31:20]};
        w_rd  = r_inst[11:7];
        w_rs1 = r_inst[19:15];
      end
      C_S: begin
        w_imm = {{20{r_inst[31]}}, r_inst[31:25], r_inst[11:7]};
        w_rs1 = r_inst[19:15];
        w_rs2 = r_inst[24:20];
      end
      C_B: begin
        w_imm = {{19{r_inst[31]}}, r_inst[31], r_inst[7], r_inst[30:25],
                 r_inst[11:8], 1'b0};
        w_rs1 = r_inst[19:15];
        w_rs2 = r_inst[24:20];
      end
      C_U: begin
        w_imm = {r_inst[31:12], 12'b0};
        w_rd  = r_inst[11:7];
      end
      C_J: begin
        w_imm = {{11{r_inst[31]}}, r_inst[31], r_inst[19:12], r_inst[20],
                 r_inst[30:21], 1'b0};
        w_rd  = r_inst[11:7];
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------- outputs
  assign D_PC       = r_pc;
  assign D_INST     = r_inst;
  assign D_VALID    = r_valid;
  assign D_OPCODE   = r_inst[6:0];
  assign D_FUNCT3   = r_inst[14:12];
  assign D_FUNCT7   = r_inst[31:25];
  assign D_IMM      = w_imm;
  assign D_REG_D    = w_rd;
  assign D_REG_S1   = w_rs1;
  assign D_REG_S2   = w_rs2;
  assign D_REG_S1_V = rf_read(w_rs1);
  assign D_REG_S2_V = rf_read(w_rs2);

endmodule

// File: tb/tb_decode.sv
// tb_decode -- directed-vector bench for decode. Inputs change #1 after a
// rising edge; the combinational D_* outputs are sampled in that same window.
module tb_decode;

  logic        CLK = 1'b0;
  logic        RST, STALL, FLUSH, F_VALID, W_VALID;
  logic [31:0] F_PC, F_INST, W_REG_D_V;
  logic [4:0]  W_REG_D;
  logic [31:0] D_PC, D_INST, D_IMM, D_REG_S1_V, D_REG_S2_V;
  logic        D_VALID;
  logic [6:0]  D_OPCODE, D_FUNCT7;
  logic [2:0]  D_FUNCT3;
  logic [4:0]  D_REG_D, D_REG_S1, D_REG_S2;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  decode dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH),
    .F_PC(F_PC), .F_INST(F_INST), .F_VALID(F_VALID),
    .W_VALID(W_VALID), .W_REG_D(W_REG_D), .W_REG_D_V(W_REG_D_V),
    .D_PC(D_PC), .D_INST(D_INST), .D_VALID(D_VALID),
    .D_OPCODE(D_OPCODE), .D_FUNCT3(D_FUNCT3), .D_FUNCT7(D_FUNCT7),
    .D_IMM(D_IMM), .D_REG_D(D_REG_D), .D_REG_S1(D_REG_S1), .D_REG_S2(D_REG_S2),
    .D_REG_S1_V(D_REG_S1_V), .D_REG_S2_V(D_REG_S2_V)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Latch one instruction with no stall/flush/write and land after the edge.
  task automatic issue(input logic [31:0] pc, input logic [31:0] inst);
    F_PC = pc; F_INST = inst; F_VALID = 1'b1;
    step();
  endtask

  task automatic chk_fields(input string tag, input logic [31:0] imm,
                            input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2);
    chk({tag, ".imm"}, D_IMM, imm);
    chk({tag, ".rd"},  {27'b0, D_REG_D},  {27'b0, rd});
    chk({tag, ".rs1"}, {27'b0, D_REG_S1}, {27'b0, rs1});
    chk({tag, ".rs2"}, {27'b0, D_REG_S2}, {27'b0, rs2});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; STALL = 1'b0; FLUSH = 1'b0;
    F_PC = 32'h0; F_INST = 32'h0; F_VALID = 1'b1;
    W_VALID = 1'b1; W_REG_D = 5'd4; W_REG_D_V = 32'h5555;  // must be overridden by reset
    step(); step();
    RST = 1'b0; W_VALID = 1'b0; F_VALID = 1'b0;

    // reset state
    chk("rst.valid",  {31'b0, D_VALID}, 32'd0);
    chk("rst.pc",     D_PC, 32'd0);
    chk("rst.inst",   D_INST, 32'h13);
    chk("rst.opcode", {25'b0, D_OPCODE}, 32'h13);
    chk_fields("rst", 32'd0, 5'd0, 5'd0, 5'd0);
    chk("rst.s1v", D_REG_S1_V, 32'd0);
    chk("rst.s2v", D_REG_S2_V, 32'd0);

    // addi x1,x0,5
    issue(32'h100, 32'h0050_0093);
    chk("addi.valid", {31'b0, D_VALID}, 32'd1);
    chk("addi.pc", D_PC, 32'h100);
    chk_fields("addi", 32'd5, 5'd1, 5'd0, 5'd0);
    chk("addi.s1v", D_REG_S1_V, 32'd0);

    // write x1 = 0x1234, then addi x2,x1,-1 reads it from storage
    W_VALID = 1'b1; W_REG_D = 5'd1; W_REG_D_V = 32'h1234;
    step();
    W_VALID = 1'b0;
    issue(32'h104, 32'hFFF0_8113);
    chk_fields("addim1", 32'hFFFF_FFFF, 5'd2, 5'd1, 5'd0);
    chk("addim1.s1v", D_REG_S1_V, 32'h1234);

    // sw x2,8(x1)
    issue(32'h108, 32'h0020_A423);
    chk_fields("sw", 32'd8, 5'd0, 5'd1, 5'd2);
    chk("sw.funct3", {29'b0, D_FUNCT3}, 32'd2);
    chk("sw.s1v", D_REG_S1_V, 32'h1234);
    chk("sw.s2v", D_REG_S2_V, 32'd0);

    // beq x0,x0,-4 : imm = {1,1,111111,1110,0} sign-extended
    issue(32'h10C, 32'hFE00_0EE3);
    chk_fields("beq", 32'hFFFF_FFFC, 5'd0, 5'd0, 5'd0);

    // lui x3,0x12345
    issue(32'h110, 32'h1234_51B7);
    chk_fields("lui", 32'h1234_5000, 5'd3, 5'd0, 5'd0);

    // jal x1,8
    issue(32'h114, 32'h0080_00EF);
    chk_fields("jal", 32'd8, 5'd1, 5'd0, 5'd0);

    // sub x3,x1,x2
    issue(32'h118, 32'h4020_81B3);
    chk_fields("sub", 32'd0, 5'd3, 5'd1, 5'd2);
    chk("sub.funct7", {25'b0, D_FUNCT7}, 32'h20);

    // unknown opcode 0x7F passes through valid with zero fields
    issue(32'h11C, 32'hFFFF_FFFF);
    chk("unk.valid", {31'b0, D_VALID}, 32'd1);
    chk("unk.opcode", {25'b0, D_OPCODE}, 32'h7F);
    chk_fields("unk", 32'd0, 5'd0, 5'd0, 5'd0);

    // add x3,x1,x1 with same-cycle write of x1: both ports bypass
    issue(32'h120, 32'h0010_81B3);
    chk("byp.pre", D_REG_S1_V, 32'h1234);
    W_VALID = 1'b1; W_REG_D = 5'd1; W_REG_D_V = 32'hCAFE_F00D;
    #1;
    chk("byp.s1v", D_REG_S1_V, 32'hCAFE_F00D);
    chk("byp.s2v", D_REG_S2_V, 32'hCAFE_F00D);
    step();
    W_VALID = 1'b0;
    #1;
    chk("byp.stored", D_REG_S1_V, 32'hCAFE_F00D);

    // add x0,x0,x0 while writing x0: stays zero, now and after the edge
    issue(32'h124, 32'h0000_0033);
    W_VALID = 1'b1; W_REG_D = 5'd0; W_REG_D_V = 32'h0000_DEAD;
    #1;
    chk("x0.byp", D_REG_S1_V, 32'd0);
    step();
    W_VALID = 1'b0;
    #1;
    chk("x0.after", D_REG_S2_V, 32'd0);

    // stall holds the latch for three cycles while fetch keeps changing
    issue(32'h200, 32'h0050_0093);
    STALL = 1'b1;
    for (int k = 0; k < 3; k++) begin
      F_PC = 32'h300 + 4 * k; F_INST = 32'h0000_0033 + (k << 7); F_VALID = 1'b1;
      step();
      chk("stall.pc", D_PC, 32'h200);
      chk("stall.inst", D_INST, 32'h0050_0093);
    end
    // flush beats stall
    FLUSH = 1'b1; F_PC = 32'h400;
    step();
    FLUSH = 1'b0; STALL = 1'b0;
    chk("flush.valid", {31'b0, D_VALID}, 32'd0);
    chk("flush.inst", D_INST, 32'h13);
    chk("flush.pc", D_PC, 32'h400);

    // write x5=7, read it, then reset mid-stream clears both latch and file
    W_VALID = 1'b1; W_REG_D = 5'd5; W_REG_D_V = 32'd7;
    step();
    W_VALID = 1'b0;
    issue(32'h500, 32'h0002_8313);   // addi x6,x5,0
    chk("x5.pre", D_REG_S1_V, 32'd7);
    RST = 1'b1; FLUSH = 1'b0; STALL = 1'b0; F_VALID = 1'b1;
    step();
    RST = 1'b0;
    chk("rst2.valid", {31'b0, D_VALID}, 32'd0);
    chk("rst2.inst", D_INST, 32'h13);
    issue(32'h504, 32'h0002_8313);
    chk("rst2.valid2", {31'b0, D_VALID}, 32'd1);
    chk("rst2.x5", D_REG_S1_V, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
